ahb_master_if: RTL and testbench

- AHB-Lite initiator for the AHB-to-APB bridge subsystem; drives the address/control/write-data signals that the bridge's AHB slave interface samples.
- Accepts one command at a time (single or INCR burst, read or write), runs the pipelined address/data phases and honours Hready wait states.
- Returns read data and completion/error status to the local requester.
- Used as the bridge's traffic source in subsystem integration and as a reusable bus master.

---
 rtl/ahb_master_if.sv | 202 ++++++++++++++++++++
 tb/tb_ahb_master_if.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_if.sv
// ---------------------------------------------------------------------------
// ahb_master_if
//
// Purpose:
//   AHB-Lite initiator. It accepts one command at a time from a local
//   requester: a single transfer or an INCR burst, read or write. It drives
//   the pipelined address and data phases, honours Hready wait states, and
//   returns read data and completion status to the requester.
//
// Optional feature (macro AHB_MST_ERR_ABORT_EN):
//   When the macro is defined, the first ERROR cycle (Hresp=01, Hready=0)
//   cancels any pending address. The command then ends with done and err
//   pulsing together.
//   When the macro is undefined, Hresp is ignored and err stays 0.
//
// Ports:
//   Hclk, Hresetn         clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_write/addr/len    direction, word-aligned start address, beats-1
//   wr_data/wr_pop        write-data source; word consumed when wr_pop=1
//   Hready/Hresp/Hrdata   AHB slave response inputs
//   Haddr/Htrans/Hwrite   AHB address/control outputs (registered)
//   Hsize/Hburst/Hwdata   word size, SINGLE/INCR, data-phase write word
//   rd_valid/rd_data      one pulse per read beat with its data
//   busy/done/err         command in progress, completion pulse, error pulse
// ---------------------------------------------------------------------------
module ahb_master_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LENW = 4
) (
  input  logic            Hclk,
  input  logic            Hresetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LENW-1:0] cmd_len,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_pop,
  input  logic            Hready,
  input  logic [1:0]      Hresp,
  input  logic [DW-1:0]   Hrdata,
  output logic [AW-1:0]   Haddr,
  output logic [1:0]      Htrans,
  output logic            Hwrite,
  output logic [2:0]      Hsize,
  output logic [2:0]      Hburst,
  output logic [DW-1:0]   Hwdata,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    LAST = 2'b10
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   haddr_q;
  logic [1:0]      htrans_q;
  logic            hwrite_q;
  logic [2:0]      hburst_q;
  logic [DW-1:0]   hwdata_q;
  logic [LENW-1:0] beatCnt_q;
  logic            dataPhase_q;
  logic            errPend_q;
  logic            rdValid_q;
  logic [DW-1:0]   rdData_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic [AW-1:0]   nextAddr_d;
  logic            errStart;

  // The next beat address wraps modulo 2^AW, so 0xFFFF_FFFC + 4 gives 0.
  assign nextAddr_d = haddr_q + AW'(4);

  // An error abort starts on the first cycle of a two-cycle ERROR response
  // to a data phase that is still in flight. Without the feature, Hresp is
  // deliberately unused.
`ifdef AHB_MST_ERR_ABORT_EN
  assign errStart = dataPhase_q && !errPend_q && (Hresp == 2'b01) && !Hready;
`else
  logic unused_hresp;
  assign unused_hresp = ^Hresp;
  assign errStart     = 1'b0;
`endif

  // Commands are only taken while idle. This guarantees an IDLE bus cycle
  // between commands.
  assign cmd_ready = (state_q == IDLE);

  // A write word is consumed exactly when its address phase completes.
  assign wr_pop    = (state_q == ADDR) && hwrite_q && Hready;

  assign Haddr     = haddr_q;
  assign Htrans    = htrans_q;
  assign Hwrite    = hwrite_q;
  assign Hsize     = 3'b010;
  assign Hburst    = hburst_q;
  assign Hwdata    = hwdata_q;
  assign rd_valid  = rdValid_q;
  assign rd_data   = rdData_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  // Main sequencer. dataPhase_q tracks whether a data phase is on the bus,
  // independently of the address-phase state. The data phase of one beat
  // completes at the same edge as the address phase of the next beat.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= IDLE;
      haddr_q     <= '0;
      htrans_q    <= TRANS_IDLE;
      hwrite_q    <= 1'b0;
      hburst_q    <= 3'b000;
      hwdata_q    <= '0;
      beatCnt_q   <= '0;
      dataPhase_q <= 1'b0;
      errPend_q   <= 1'b0;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rdValid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;

      // Data phase completion. Read data from the second ERROR cycle is
      // not returned.
      if (dataPhase_q && Hready) begin
        dataPhase_q <= 1'b0;
        if (!hwrite_q && !errPend_q) begin
          rdValid_q <= 1'b1;
          rdData_q  <= Hrdata;
        end
      end

      if (errStart) begin
        // Drop any address that is waiting, then let LAST finish the command.
        htrans_q  <= TRANS_IDLE;
        errPend_q <= 1'b1;
        state_q   <= LAST;
      end else begin
        case (state_q)
          IDLE: begin
            if (cmd_valid) begin
              haddr_q   <= cmd_addr;
              htrans_q  <= TRANS_NONSEQ;
              hwrite_q  <= cmd_write;
              hburst_q  <= (cmd_len == '0) ? 3'b000 : 3'b001;
              beatCnt_q <= cmd_len;
              busy_q    <= 1'b1;
              state_q   <= ADDR;
            end
          end
          ADDR: begin
            if (Hready) begin
              dataPhase_q <= 1'b1;
              if (hwrite_q) begin
                hwdata_q <= wr_data;
              end
              if (beatCnt_q != '0) begin
                // A beat that lands on a 1KB boundary restarts as NONSEQ.
                haddr_q   <= nextAddr_d;
                beatCnt_q <= beatCnt_q - LENW'(1);
                htrans_q  <= (nextAddr_d[9:0] == 10'd0) ? TRANS_NONSEQ : TRANS_SEQ;
              end else begin
                htrans_q <= TRANS_IDLE;
                state_q  <= LAST;
              end
            end
          end
          LAST: begin
            if (Hready) begin
              done_q    <= 1'b1;
              err_q     <= errPend_q;
              errPend_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_if.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_if
//
// Purpose:
//   Self-checking bench for ahb_master_if.
//   A transaction-level model expands each command into the list of beats it
//   should produce. Each cycle, the model walks that list against the Hready
//   and Hresp values the bench drives. The monitor compares every output on
//   every cycle. Directed literal checks pin down the model with
//   hand-computed values.
//
// Optional feature:
//   AHB_MST_ERR_ABORT_EN selects the expected error-abort behaviour.
// ---------------------------------------------------------------------------
module tb_ahb_master_if;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LENW = 4;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
  } beat_t;

  logic            Hclk = 1'b0;
  logic            Hresetn;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [LENW-1:0] cmd_len;
  logic [DW-1:0]   wr_data;
  logic            wr_pop;
  logic            Hready;
  logic [1:0]      Hresp;
  logic [DW-1:0]   Hrdata;
  logic [AW-1:0]   Haddr;
  logic [1:0]      Htrans;
  logic            Hwrite;
  logic [2:0]      Hsize;
  logic [2:0]      Hburst;
  logic [DW-1:0]   Hwdata;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic            busy;
  logic            done;
  logic            err;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state
  beat_t       addrQ[$];
  logic        mBusy     = 1'b0;
  logic        mWrite    = 1'b0;
  logic [2:0]  mBurst    = 3'b000;
  logic        mDataPend = 1'b0;
  logic        mErrPend  = 1'b0;
  logic        mRdValid  = 1'b0;
  logic [31:0] mRdData   = '0;
  logic [31:0] mHwdata   = '0;
  logic        mDone     = 1'b0;
  logic        mErr      = 1'b0;
  int          mRdBeat   = 0;
  int          mWrIdx    = 0;

  // Observation logs, cleared when a command is accepted
  int          wrPopCnt   = 0;
  int          rdValidCnt = 0;
  int          doneCnt    = 0;
  int          errCnt     = 0;
  logic [31:0] rdLog[$];
  beat_t       addrLog[$];

  // Per-cycle snapshots, indexed by cycles since acceptance
  int          curCycle = 0;
  logic [1:0]  snTrans[64];
  logic [31:0] snAddr[64];
  logic [31:0] snHwdata[64];
  logic        snWpop[64];
  logic        snDone[64];
  logic        snBusy[64];
  logic        snHwrite[64];
  logic [2:0]  snBurst[64];

  // Stimulus sources
  logic [31:0] wrSrc[8];
  logic [31:0] rdBase = '0;

  always #5 Hclk = ~Hclk;

  ahb_master_if #(.AW(AW), .DW(DW), .LENW(LENW)) dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_pop    (wr_pop),
    .Hready    (Hready),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata),
    .Haddr     (Haddr),
    .Htrans    (Htrans),
    .Hwrite    (Hwrite),
    .Hsize     (Hsize),
    .Hburst    (Hburst),
    .Hwdata    (Hwdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare the DUT against the model at every falling edge, then
  // advance the model using the inputs the next rising edge will sample.
  always @(negedge Hclk) begin : monitor
    logic [1:0]  expTrans;
    logic [31:0] a;
    logic        finishing;
    logic        abort;
    if (!Hresetn) begin
      addrQ.delete();
      mBusy     = 1'b0;
      mDataPend = 1'b0;
      mErrPend  = 1'b0;
      mRdValid  = 1'b0;
      mDone     = 1'b0;
      mErr      = 1'b0;
    end else begin
      expTrans = (addrQ.size() != 0) ? addrQ[0].trans : 2'b00;
      checkOutput("Htrans", Htrans, expTrans);
      if (addrQ.size() != 0) begin
        checkOutput("Haddr", Haddr, addrQ[0].addr);
        checkOutput("Hwrite", Hwrite, mWrite);
        checkOutput("Hburst", Hburst, mBurst);
      end
      checkOutput("Hsize", Hsize, 3'b010);
      checkOutput("cmd_ready", cmd_ready, !mBusy);
      checkOutput("wr_pop", wr_pop, (addrQ.size() != 0) && mWrite && Hready);
      if (mDataPend && mWrite) checkOutput("Hwdata", Hwdata, mHwdata);
      checkOutput("rd_valid", rd_valid, mRdValid);
      if (mRdValid) checkOutput("rd_data", rd_data, mRdData);
      checkOutput("done", done, mDone);
      checkOutput("err", err, mErr);
      checkOutput("busy", busy, mBusy);

      if (wr_pop) wrPopCnt++;
      if (rd_valid) begin
        rdValidCnt++;
        rdLog.push_back(rd_data);
      end
      if (done) doneCnt++;
      if (err) errCnt++;
      if (Htrans != 2'b00 && Hready) addrLog.push_back('{addr: Haddr, trans: Htrans});
      if (curCycle >= 0 && curCycle < 64) begin
        snTrans[curCycle]  = Htrans;
        snAddr[curCycle]   = Haddr;
        snHwdata[curCycle] = Hwdata;
        snWpop[curCycle]   = wr_pop;
        snDone[curCycle]   = done;
        snBusy[curCycle]   = busy;
        snHwrite[curCycle] = Hwrite;
        snBurst[curCycle]  = Hburst;
      end

      // Advance the model
      mRdValid = 1'b0;
      mDone    = 1'b0;
      mErr     = 1'b0;
      if (!mBusy) begin
        if (cmd_valid) begin
          mBusy     = 1'b1;
          mWrite    = cmd_write;
          mBurst    = (cmd_len == 0) ? 3'b000 : 3'b001;
          mDataPend = 1'b0;
          mErrPend  = 1'b0;
          mRdBeat   = 0;
          mWrIdx    = 0;
          wrPopCnt  = 0;
          rdValidCnt = 0;
          doneCnt   = 0;
          errCnt    = 0;
          rdLog.delete();
          addrLog.delete();
          for (int i = 0; i <= int'(cmd_len); i++) begin
            a = cmd_addr + 32'(4 * i);
            addrQ.push_back('{addr: a, trans: (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11});
          end
        end
      end else begin
        abort = 1'b0;
`ifdef AHB_MST_ERR_ABORT_EN
        if (mDataPend && !mErrPend && Hresp == 2'b01 && !Hready) begin
          addrQ.delete();
          mErrPend = 1'b1;
          abort    = 1'b1;
        end
`endif
        if (!abort) begin
          finishing = (addrQ.size() == 0) && mDataPend && Hready;
          if (mDataPend && Hready) begin
            mDataPend = 1'b0;
            if (!mWrite && !mErrPend) begin
              mRdValid = 1'b1;
              mRdData  = Hrdata;
              mRdBeat++;
            end
          end
          if (addrQ.size() != 0 && Hready) begin
            void'(addrQ.pop_front());
            mDataPend = 1'b1;
            if (mWrite) begin
              mHwdata = wr_data;
              mWrIdx++;
            end
          end
          if (finishing) begin
            mDone    = 1'b1;
            mErr     = mErrPend;
            mBusy    = 1'b0;
            mErrPend = 1'b0;
          end
        end
      end
    end
  end

  // Issue one command, then play the Hready/Hresp pattern until the model is
  // idle. Cycle numbering starts at 1 for the cycle after acceptance.
  task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [3:0] len,
                               input int stallStart, input int stallLen, input int errCycle,
                               input int resetCycle);
    int  idleCycles;
    bit  finished;
    cmd_valid = 1'b1;
    cmd_write = write;
    cmd_addr  = addr;
    cmd_len   = len;
    Hready    = 1'b1;
    Hresp     = 2'b00;
    curCycle  = 0;
    @(posedge Hclk);
    #1;
    cmd_valid  = 1'b0;
    idleCycles = 0;
    finished   = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      curCycle = c;
      Hready   = !((stallLen > 0 && c >= stallStart && c < stallStart + stallLen) || (errCycle != 0 && c == errCycle));
      Hresp    = (errCycle != 0 && (c == errCycle || c == errCycle + 1)) ? 2'b01 : 2'b00;
      wr_data  = wrSrc[mWrIdx % 8];
      Hrdata   = rdBase + 32'(mRdBeat);
      if (c == resetCycle) begin
        Hresetn = 1'b0;
        #1;
        checkOutput("rst Htrans", Htrans, 2'b00);
        checkOutput("rst Haddr", Haddr, 32'h0);
        checkOutput("rst busy", busy, 1'b0);
        checkOutput("rst wr_pop", wr_pop, 1'b0);
        @(posedge Hclk);
        @(posedge Hclk);
        #1;
        Hresetn  = 1'b1;
        Hready   = 1'b1;
        Hresp    = 2'b00;
        curCycle = 63;
        @(posedge Hclk);
        #1;
        finished = 1'b1;
        break;
      end
      if (!mBusy) idleCycles++;
      if (idleCycles > 2) begin
        finished = 1'b1;
        break;
      end
      @(posedge Hclk);
      #1;
    end
    Hready   = 1'b1;
    Hresp    = 2'b00;
    curCycle = 63;
    if (!finished) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL timeout: command at %h still busy after 40 cycles", addr);
    end
  endtask

  initial begin
    Hresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_data   = '0;
    Hready    = 1'b1;
    Hresp     = 2'b00;
    Hrdata    = '0;
    for (int i = 0; i < 8; i++) wrSrc[i] = '0;
    repeat (2) @(posedge Hclk);
    #1;
    checkOutput("reset Haddr", Haddr, 32'h0);
    checkOutput("reset Htrans", Htrans, 2'b00);
    checkOutput("reset Hwrite", Hwrite, 1'b0);
    checkOutput("reset Hburst", Hburst, 3'b000);
    checkOutput("reset Hwdata", Hwdata, 32'h0);
    checkOutput("reset rd_valid", rd_valid, 1'b0);
    checkOutput("reset rd_data", rd_data, 32'h0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset err", err, 1'b0);
    checkOutput("reset wr_pop", wr_pop, 1'b0);
    Hresetn = 1'b1;
    @(posedge Hclk);
    #1;

    // Single write
    wrSrc[0] = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 32'h8000_0010, 4'd0, 0, 0, 0, 0);
    checkOutput("t1 c1 Haddr", snAddr[1], 32'h8000_0010);
    checkOutput("t1 c1 Htrans", snTrans[1], 2'b10);
    checkOutput("t1 c1 Hwrite", snHwrite[1], 1'b1);
    checkOutput("t1 c1 Hburst", snBurst[1], 3'b000);
    checkOutput("t1 c1 wr_pop", snWpop[1], 1'b1);
    checkOutput("t1 c2 Hwdata", snHwdata[2], 32'hDEAD_BEEF);
    checkOutput("t1 c2 Htrans", snTrans[2], 2'b00);
    checkOutput("t1 c3 done", snDone[3], 1'b1);
    checkOutput("t1 c4 busy", snBusy[4], 1'b0);
    checkOutput("t1 done count", doneCnt, 1);

    // Four-beat read, Hrdata = beat index
    rdBase = 32'h0;
    applyStimulus(1'b0, 32'h8400_0000, 4'd3, 0, 0, 0, 0);
    checkOutput("t2 beats", addrLog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2 addr", addrLog[i].addr, 32'h8400_0000 + 32'(4 * i));
      checkOutput("t2 trans", addrLog[i].trans, (i == 0) ? 2'b10 : 2'b11);
    end
    checkOutput("t2 Hburst", snBurst[1], 3'b001);
    checkOutput("t2 rd count", rdValidCnt, 4);
    for (int i = 0; i < 4; i++) checkOutput("t2 rd_data", rdLog[i], 32'(i));
    checkOutput("t2 done count", doneCnt, 1);

    // Four-beat write with two wait states in the second data phase
    wrSrc[0] = 32'h1111_1111;
    wrSrc[1] = 32'h2222_2222;
    wrSrc[2] = 32'h3333_3333;
    wrSrc[3] = 32'h4444_4444;
    applyStimulus(1'b1, 32'h1000_0000, 4'd3, 3, 2, 0, 0);
    checkOutput("t3 wr_pop count", wrPopCnt, 4);
    checkOutput("t3 c3 Hwdata", snHwdata[3], 32'h2222_2222);
    checkOutput("t3 c4 Hwdata", snHwdata[4], 32'h2222_2222);
    checkOutput("t3 c4 Haddr", snAddr[4], 32'h1000_0008);
    checkOutput("t3 c4 Htrans", snTrans[4], 2'b11);
    checkOutput("t3 c4 wr_pop", snWpop[4], 1'b0);
    checkOutput("t3 c7 Hwdata", snHwdata[7], 32'h4444_4444);
    checkOutput("t3 done count", doneCnt, 1);

    // Burst crossing a 1KB boundary
    applyStimulus(1'b0, 32'h8000_03F8, 4'd3, 0, 0, 0, 0);
    checkOutput("t4 beats", addrLog.size(), 4);
    checkOutput("t4 a0", {addrLog[0].addr, 6'd0, addrLog[0].trans}, {32'h8000_03F8, 6'd0, 2'b10});
    checkOutput("t4 a1", {addrLog[1].addr, 6'd0, addrLog[1].trans}, {32'h8000_03FC, 6'd0, 2'b11});
    checkOutput("t4 a2", {addrLog[2].addr, 6'd0, addrLog[2].trans}, {32'h8000_0400, 6'd0, 2'b10});
    checkOutput("t4 a3", {addrLog[3].addr, 6'd0, addrLog[3].trans}, {32'h8000_0404, 6'd0, 2'b11});

    // Address wrap at the top of the map
    rdBase = 32'hA5A5_0000;
    applyStimulus(1'b0, 32'hFFFF_FFFC, 4'd1, 0, 0, 0, 0);
    checkOutput("wrap a1", {addrLog[1].addr, 6'd0, addrLog[1].trans}, {32'h0000_0000, 6'd0, 2'b10});
    checkOutput("wrap rd0", rdLog[0], 32'hA5A5_0000);
    checkOutput("wrap rd1", rdLog[1], 32'hA5A5_0001);

    // Reset in the middle of a write burst, then a clean single read
    applyStimulus(1'b1, 32'h2000_0000, 4'd3, 0, 0, 0, 3);
    checkOutput("t5 no done", doneCnt, 0);
    rdBase = 32'hCAFE_0000;
    applyStimulus(1'b0, 32'h8000_0100, 4'd0, 0, 0, 0, 0);
    checkOutput("t5 rd count", rdValidCnt, 1);
    checkOutput("t5 rd data", rdLog[0], 32'hCAFE_0000);
    checkOutput("t5 done count", doneCnt, 1);

    // ERROR response on the first beat of a four-beat write
    applyStimulus(1'b1, 32'h9000_0000, 4'd3, 0, 0, 2, 0);
    checkOutput("t6 done count", doneCnt, 1);
`ifdef AHB_MST_ERR_ABORT_EN
    checkOutput("t6 beats", addrLog.size(), 1);
    checkOutput("t6 wr_pop count", wrPopCnt, 1);
    checkOutput("t6 c3 Htrans", snTrans[3], 2'b00);
    checkOutput("t6 c4 done", snDone[4], 1'b1);
    checkOutput("t6 err count", errCnt, 1);
`else
    checkOutput("t6 beats", addrLog.size(), 4);
    checkOutput("t6 wr_pop count", wrPopCnt, 4);
    checkOutput("t6 err count", errCnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
